// File: rtl/branch_predict_unit.sv
// ---------------------------------------------------------------------------
// branch_predict_unit
//
// Branch/jump resolution with a direct-mapped branch target buffer (BTB) and
// 2-bit saturating direction counters.
//
// The fetch side looks up the BTB with the fetch PC and produces a purely
// combinational taken/target prediction. The execute side resolves B-type,
// JAL and JALR instructions against the prediction that travelled down the
// pipe with them. It trains the BTB and raises a one-cycle registered
// redirect whenever that prediction was wrong.
//
// Ports
//    clk               rising-edge clock
//    rst_n             asynchronous active-low reset
//    if_pc             fetch PC to predict
//    if_pred_taken     predicted taken for if_pc (combinational)
//    if_pred_target    predicted next PC for if_pc (combinational)
//    ex_valid          EX stage holds a valid instruction
//    ex_opcode         EX instruction opcode
//    ex_func3          EX instruction func3
//    ex_pc             PC of the EX instruction
//    ex_imm            sign-extended immediate of the EX instruction
//    ex_rs1, ex_rs2    operand values
//    ex_pred_taken     prediction made at fetch for this instruction
//    ex_pred_target    predicted target made at fetch for this instruction
//    flush_valid       one-cycle redirect pulse (kill younger instructions)
//    flush_pc          correct next PC while flush_valid is high
//    stat_branches     saturating count of resolved control transfers
//    stat_mispredicts  saturating count of mispredicted control transfers
// ---------------------------------------------------------------------------
module branch_predict_unit #(
   parameter int XLEN  = 32,
   parameter int IDX_W = 6,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [XLEN-1:0]  if_pc,
   output logic             if_pred_taken,
   output logic [XLEN-1:0]  if_pred_target,
   input  logic             ex_valid,
   input  logic [6:0]       ex_opcode,
   input  logic [2:0]       ex_func3,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic [XLEN-1:0]  ex_imm,
   input  logic [XLEN-1:0]  ex_rs1,
   input  logic [XLEN-1:0]  ex_rs2,
   input  logic             ex_pred_taken,
   input  logic [XLEN-1:0]  ex_pred_target,
   output logic             flush_valid,
   output logic [XLEN-1:0]  flush_pc,
   output logic [CNT_W-1:0] stat_branches,
   output logic [CNT_W-1:0] stat_mispredicts
);

   localparam int ENTRIES = 2 ** IDX_W;
   localparam int TAG_W   = XLEN - IDX_W - 2;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [1:0] CTR_INIT  = 2'b01;
   localparam logic [1:0] CTR_ALLOC = 2'b10;
   localparam logic [1:0] CTR_MAX   = 2'b11;
   localparam logic [1:0] CTR_MIN   = 2'b00;

   // BTB storage. Valid bits and counters carry a reset value. Tag, target
   // and jump are only meaningful behind a set valid bit, so they stay
   // reset-free.
   logic [ENTRIES-1:0] btb_valid;
   logic [ENTRIES-1:0] btb_jump;
   logic [1:0]         btb_ctr    [ENTRIES];
   logic [TAG_W-1:0]   btb_tag    [ENTRIES];
   logic [XLEN-1:0]    btb_target [ENTRIES];

   // ------------------------------------------------------------------
   // Fetch-side lookup
   // ------------------------------------------------------------------
   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   logic             if_hit;

   assign if_idx = if_pc[IDX_W+1:2];
   assign if_tag = if_pc[XLEN-1:IDX_W+2];
   assign if_hit = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);

   // An unconditional jump in the BTB is always predicted taken. Branches
   // follow the counter MSB. On a hit the stored target is reported even
   // when the prediction is not-taken, so fetch can choose between the two.
   assign if_pred_taken  = if_hit && (btb_jump[if_idx] || btb_ctr[if_idx][1]);
   assign if_pred_target = if_hit ? btb_target[if_idx] : (if_pc + XLEN'(4));

   // ------------------------------------------------------------------
   // Execute-side decode and resolution
   // ------------------------------------------------------------------
   logic             br_func_ok;
   logic             br_cond;
   logic             is_branch;
   logic             is_jal;
   logic             is_jalr;
   logic             squashed;
   logic             resolve;
   logic             taken;
   logic [XLEN-1:0]  target;
   logic [XLEN-1:0]  correct_pc;
   logic             mispredict;

   // Evaluate the branch condition from func3. func3 010 and 011 are not
   // branches, so br_func_ok drops and the instruction is treated as a
   // non-control op.
   always_comb begin
      br_func_ok = 1'b1;
      br_cond    = 1'b0;
      case (ex_func3)
         3'b000:  br_cond = (ex_rs1 == ex_rs2);
         3'b001:  br_cond = (ex_rs1 != ex_rs2);
         3'b100:  br_cond = ($signed(ex_rs1) <  $signed(ex_rs2));
         3'b101:  br_cond = ($signed(ex_rs1) >= $signed(ex_rs2));
         3'b110:  br_cond = (ex_rs1 <  ex_rs2);
         3'b111:  br_cond = (ex_rs1 >= ex_rs2);
         default: br_func_ok = 1'b0;
      endcase
   end

   assign is_branch = (ex_opcode == OP_BRANCH) && br_func_ok;
   assign is_jal    = (ex_opcode == OP_JAL);
   assign is_jalr   = (ex_opcode == OP_JALR);

   // Whatever sits in EX while a redirect is on the way out was fetched
   // down the wrong path, so it must not resolve.
   assign squashed  = flush_valid;
   assign resolve   = ex_valid && !squashed && (is_branch || is_jal || is_jalr);

   assign taken     = is_jal || is_jalr || (is_branch && br_cond);

   // JALR clears bit 0 of the computed address. Every add wraps modulo
   // 2**XLEN, so PC wrap-around needs no special handling.
   assign target    = is_jalr ? ((ex_rs1 + ex_imm) & ~XLEN'(1))
                              : (ex_pc + ex_imm);
   assign correct_pc = taken ? target : (ex_pc + XLEN'(4));

   assign mispredict = resolve &&
                       ((taken != ex_pred_taken) ||
                        (taken && (target != ex_pred_target)));

   // Execute-side BTB lookup, used to choose between training an existing
   // entry and allocating a new one.
   logic [IDX_W-1:0] ex_idx;
   logic [TAG_W-1:0] ex_tag;
   logic             ex_hit;

   assign ex_idx = ex_pc[IDX_W+1:2];
   assign ex_tag = ex_pc[XLEN-1:IDX_W+2];
   assign ex_hit = btb_valid[ex_idx] && (btb_tag[ex_idx] == ex_tag);

   // ------------------------------------------------------------------
   // Redirect register
   // ------------------------------------------------------------------
   // flush_valid is a single-cycle pulse. It can only repeat if a new,
   // non-squashed instruction mispredicts, and the squash rule prevents
   // that in the cycle right after a pulse. flush_pc holds its last value
   // between pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_valid <= 1'b0;
         flush_pc    <= '0;
      end else begin
         flush_valid <= mispredict;
         if (mispredict) begin
            flush_pc <= correct_pc;
         end
      end
   end

   // ------------------------------------------------------------------
   // Statistics counters
   // ------------------------------------------------------------------
   // Both counters stop at all-ones instead of wrapping, so a long run
   // cannot report a small count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_branches    <= '0;
         stat_mispredicts <= '0;
      end else begin
         if (resolve && (stat_branches != '1)) begin
            stat_branches <= stat_branches + CNT_W'(1);
         end
         if (mispredict && (stat_mispredicts != '1)) begin
            stat_mispredicts <= stat_mispredicts + CNT_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // BTB training: valid bits and direction counters
   // ------------------------------------------------------------------
   // A taken hit strengthens the counter and a not-taken hit weakens it,
   // saturating at both ends. A taken miss allocates the entry in the
   // weakly-taken state. A not-taken miss leaves the BTB alone, so that
   // never-taken branches do not evict useful entries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btb_valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            btb_ctr[i] <= CTR_INIT;
         end
      end else if (resolve) begin
         if (taken) begin
            if (ex_hit) begin
               if (btb_ctr[ex_idx] != CTR_MAX) begin
                  btb_ctr[ex_idx] <= btb_ctr[ex_idx] + 2'd1;
               end
            end else begin
               btb_valid[ex_idx] <= 1'b1;
               btb_ctr[ex_idx]   <= CTR_ALLOC;
            end
         end else if (ex_hit && (btb_ctr[ex_idx] != CTR_MIN)) begin
            btb_ctr[ex_idx] <= btb_ctr[ex_idx] - 2'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // BTB training: tag, target and jump flag
   // ------------------------------------------------------------------
   // Any taken resolution rewrites these fields. On a hit the tag is
   // unchanged, and the target may move (for example a JALR with a new
   // rs1). A fetch read in the same cycle sees the pre-edge contents
   // because there is no bypass path.
   always_ff @(posedge clk) begin
      if (resolve && taken) begin
         btb_tag[ex_idx]    <= ex_tag;
         btb_target[ex_idx] <= target;
         btb_jump[ex_idx]   <= is_jal || is_jalr;
      end
   end

endmodule

// File: tb/tb_branch_predict_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_predict_unit
//
// Directed bench for branch_predict_unit. The statistics counters are
// narrowed to 8 bits so that their saturation point can be reached in a
// short run.
// ---------------------------------------------------------------------------
module tb_branch_predict_unit;

   localparam int XLEN  = 32;
   localparam int IDX_W = 6;
   localparam int CNT_W = 8;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [XLEN-1:0]  if_pc;
   logic             if_pred_taken;
   logic [XLEN-1:0]  if_pred_target;
   logic             ex_valid;
   logic [6:0]       ex_opcode;
   logic [2:0]       ex_func3;
   logic [XLEN-1:0]  ex_pc;
   logic [XLEN-1:0]  ex_imm;
   logic [XLEN-1:0]  ex_rs1;
   logic [XLEN-1:0]  ex_rs2;
   logic             ex_pred_taken;
   logic [XLEN-1:0]  ex_pred_target;
   logic             flush_valid;
   logic [XLEN-1:0]  flush_pc;
   logic [CNT_W-1:0] stat_branches;
   logic [CNT_W-1:0] stat_mispredicts;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [CNT_W-1:0] exp_br  = '0;
   logic [CNT_W-1:0] exp_mis = '0;

   branch_predict_unit #(
      .XLEN  (XLEN),
      .IDX_W (IDX_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .if_pc            (if_pc),
      .if_pred_taken    (if_pred_taken),
      .if_pred_target   (if_pred_target),
      .ex_valid         (ex_valid),
      .ex_opcode        (ex_opcode),
      .ex_func3         (ex_func3),
      .ex_pc            (ex_pc),
      .ex_imm           (ex_imm),
      .ex_rs1           (ex_rs1),
      .ex_rs2           (ex_rs2),
      .ex_pred_taken    (ex_pred_taken),
      .ex_pred_target   (ex_pred_target),
      .flush_valid      (flush_valid),
      .flush_pc         (flush_pc),
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
   );

   // Free-running 10-time-unit clock
   always #5 clk = ~clk;

   // Single comparison point: counts the check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one EX-stage instruction
   task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [2:0] f3,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic ptaken, input logic [31:0] ptarget);
      ex_valid       = v;
      ex_opcode      = op;
      ex_func3       = f3;
      ex_pc          = pc;
      ex_imm         = imm;
      ex_rs1         = rs1;
      ex_rs2         = rs2;
      ex_pred_taken  = ptaken;
      ex_pred_target = ptarget;
   endtask

   task automatic idleEx();
      ex_valid = 1'b0;
   endtask

   // Advance one clock and sample just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference statistics with saturation at all-ones
   task automatic countResolve(input logic mis);
      if (exp_br != '1) exp_br = exp_br + 1'b1;
      if (mis && (exp_mis != '1)) exp_mis = exp_mis + 1'b1;
   endtask

   task automatic checkStats(input string tag);
      checkOutput({tag, ".stat_branches"}, 32'(stat_branches), 32'(exp_br));
      checkOutput({tag, ".stat_mispredicts"}, 32'(stat_mispredicts), 32'(exp_mis));
   endtask

   task automatic checkFlush(input string tag, input logic fv, input logic [31:0] fpc);
      checkOutput({tag, ".flush_valid"}, 32'(flush_valid), 32'(fv));
      if (fv) checkOutput({tag, ".flush_pc"}, flush_pc, fpc);
   endtask

   task automatic checkPredict(input string tag, input logic [31:0] pc,
                               input logic taken, input logic [31:0] tgt);
      if_pc = pc;
      #1;
      checkOutput({tag, ".if_pred_taken"}, 32'(if_pred_taken), 32'(taken));
      checkOutput({tag, ".if_pred_target"}, if_pred_target, tgt);
   endtask

   initial begin
      rst_n = 1'b0;
      if_pc = 32'h100;
      applyStimulus(1'b0, 7'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
      #12;

      // Reset state
      checkFlush("reset", 1'b0, 32'd0);
      checkOutput("reset.flush_pc", flush_pc, 32'd0);
      checkStats("reset");
      checkPredict("reset", 32'h100, 1'b0, 32'h104);

      @(negedge clk);
      rst_n = 1'b1;

      // beq taken while predicted not-taken: redirect to 0x120 and allocate
      applyStimulus(1'b1, OP_BRANCH, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h104);
      tick();
      countResolve(1'b1);
      checkFlush("beq_mis", 1'b1, 32'h120);
      checkStats("beq_mis");
      idleEx();
      checkPredict("beq_alloc", 32'h100, 1'b1, 32'h120);
      tick();
      checkFlush("beq_pulse_end", 1'b0, 32'd0);

      // bltu: 1 < 0xFFFFFFFF unsigned, so taken and correctly predicted
      applyStimulus(1'b1, OP_BRANCH, 3'b110, 32'h204, 32'h40, 32'd1, 32'hFFFF_FFFF, 1'b1, 32'h244);
      tick();
      countResolve(1'b0);
      checkFlush("bltu", 1'b0, 32'd0);
      checkStats("bltu");
      checkPredict("bltu_alloc", 32'h204, 1'b1, 32'h244);

      // blt: 1 < -1 signed is false, so not taken, correctly predicted
      applyStimulus(1'b1, OP_BRANCH, 3'b100, 32'h208, 32'h40, 32'd1, 32'hFFFF_FFFF, 1'b0, 32'h20C);
      tick();
      countResolve(1'b0);
      checkFlush("blt", 1'b0, 32'd0);
      checkStats("blt");
      checkPredict("blt_no_alloc", 32'h208, 1'b0, 32'h20C);

      // JALR 0x203+0 -> 0x202 (bit 0 cleared), correctly predicted
      applyStimulus(1'b1, OP_JALR, 3'b000, 32'h30C, 32'h0, 32'h203, 32'd0, 1'b1, 32'h202);
      tick();
      countResolve(1'b0);
      checkFlush("jalr", 1'b0, 32'd0);
      checkStats("jalr");
      checkPredict("jalr_alloc", 32'h30C, 1'b1, 32'h202);

      // JAL mispredict, then a wrong-path beq that would also mispredict
      applyStimulus(1'b1, OP_JAL, 3'b000, 32'h410, 32'h100, 32'd0, 32'd0, 1'b0, 32'h414);
      tick();
      countResolve(1'b1);
      checkFlush("jal_mis", 1'b1, 32'h510);
      checkStats("jal_mis");
      applyStimulus(1'b1, OP_BRANCH, 3'b000, 32'h414, 32'h8, 32'd7, 32'd7, 1'b0, 32'h418);
      tick();
      checkFlush("squash", 1'b0, 32'd0);
      checkStats("squash");
      idleEx();
      checkPredict("squash_no_train", 32'h414, 1'b0, 32'h418);

      // PC wrap-around: 0xFFFFFFF8 + 0x10 = 0x8
      applyStimulus(1'b1, OP_JAL, 3'b000, 32'hFFFF_FFF8, 32'h10, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFC);
      tick();
      countResolve(1'b1);
      checkFlush("wrap", 1'b1, 32'h8);
      checkStats("wrap");
      idleEx();
      tick();

      // func3 010 under the branch opcode, and a non-control opcode: no action
      applyStimulus(1'b1, OP_BRANCH, 3'b010, 32'h500, 32'h20, 32'd3, 32'd3, 1'b1, 32'h520);
      tick();
      checkFlush("f3_010", 1'b0, 32'd0);
      checkStats("f3_010");
      applyStimulus(1'b1, OP_ALUI, 3'b000, 32'h504, 32'h20, 32'd3, 32'd3, 1'b1, 32'h524);
      tick();
      checkFlush("non_ctrl", 1'b0, 32'd0);
      checkStats("non_ctrl");

      // Counter at 0x100: 10 -> three taken -> 11 -> one not-taken -> 10
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, OP_BRANCH, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1, 32'h120);
         tick();
         countResolve(1'b0);
         checkFlush("ctr_up", 1'b0, 32'd0);
      end
      applyStimulus(1'b1, OP_BRANCH, 3'b001, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1, 32'h120);
      tick();
      countResolve(1'b1);
      checkFlush("ctr_nt1", 1'b1, 32'h104);
      checkStats("ctr_nt1");
      idleEx();
      checkPredict("ctr_weak_taken", 32'h100, 1'b1, 32'h120);
      tick();
      // A second not-taken drops the counter to 01: hit, predicts not-taken
      applyStimulus(1'b1, OP_BRANCH, 3'b001, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1, 32'h120);
      tick();
      countResolve(1'b1);
      checkFlush("ctr_nt2", 1'b1, 32'h104);
      idleEx();
      checkPredict("ctr_weak_nt", 32'h100, 1'b0, 32'h120);
      tick();

      // Drive repeated mispredicts until both counters saturate
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, OP_JAL, 3'b000, 32'h600, 32'h4, 32'd0, 32'd0, 1'b0, 32'h604);
         tick();
         countResolve(1'b1);
         idleEx();
         tick();
      end
      checkStats("saturate");
      checkOutput("saturate.max", 32'(stat_mispredicts), 32'hFF);

      // Async reset in the middle of a flush pulse
      applyStimulus(1'b1, OP_JAL, 3'b000, 32'h700, 32'h40, 32'd0, 32'd0, 1'b0, 32'h704);
      tick();
      checkFlush("pre_reset", 1'b1, 32'h740);
      idleEx();
      rst_n = 1'b0;
      #1;
      exp_br  = '0;
      exp_mis = '0;
      checkFlush("async_reset", 1'b0, 32'd0);
      checkOutput("async_reset.flush_pc", flush_pc, 32'd0);
      checkStats("async_reset");
      checkPredict("async_reset", 32'h204, 1'b0, 32'h208);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
